// File: rtl/axi_sp32b1024_interconnect.sv
// AXI4-Lite slave in front of a single-port 1024 x 32 synchronous SRAM.
// One FSM serializes accesses one at a time; a pending write always wins over a read.
module axi_sp32b1024_interconnect #(
  parameter int BITS       = 32,
  parameter int WORD_DEPTH = 1024,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                axi_awvalid,
  output logic                axi_awready,
  input  logic [31:0]         axi_awaddr,
  input  logic [2:0]          axi_awprot,
  input  logic                axi_wvalid,
  output logic                axi_wready,
  input  logic [BITS-1:0]     axi_wdata,
  input  logic [BITS/8-1:0]   axi_wstrb,
  output logic                axi_bvalid,
  input  logic                axi_bready,
  input  logic                axi_arvalid,
  output logic                axi_arready,
  input  logic [31:0]         axi_araddr,
  input  logic [2:0]          axi_arprot,
  output logic                axi_rvalid,
  input  logic                axi_rready,
  output logic [BITS-1:0]     axi_rdata
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    AW_ACK  = 3'd1,
    W_WAIT  = 3'd2,
    B_RESP  = 3'd3,
    AR_ACK  = 3'd4,
    R_FETCH = 3'd5,
    R_DATA  = 3'd6
  } state_t;

  state_t                state_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [BITS-1:0]       mem_r [WORD_DEPTH];
  logic [BITS-1:0]       rd_data_r;
  logic                  wr_en_s;
  logic                  rd_en_s;
  logic                  unused_s;

  // Only the word index matters; protection bits and upper address bits are don't-care.
  assign unused_s = ^{axi_awprot, axi_arprot,
                      axi_awaddr[31:ADDR_WIDTH], axi_araddr[31:ADDR_WIDTH]};

  assign wr_en_s = (state_r == W_WAIT) && axi_wvalid;
  assign rd_en_s = (state_r == AR_ACK);

  // Transaction sequencer; every handshake output is a register of this FSM.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r     <= IDLE;
      addr_r      <= '0;
      axi_awready <= 1'b0;
      axi_wready  <= 1'b0;
      axi_bvalid  <= 1'b0;
      axi_arready <= 1'b0;
      axi_rvalid  <= 1'b0;
      axi_rdata   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (axi_awvalid) begin
            addr_r      <= axi_awaddr[ADDR_WIDTH-1:0];
            axi_awready <= 1'b1;
            state_r     <= AW_ACK;
          end else if (axi_arvalid) begin
            addr_r      <= axi_araddr[ADDR_WIDTH-1:0];
            axi_arready <= 1'b1;
            state_r     <= AR_ACK;
          end
        end
        AW_ACK: begin
          axi_awready <= 1'b0;
          axi_wready  <= 1'b1;
          state_r     <= W_WAIT;
        end
        W_WAIT: begin
          if (axi_wvalid) begin
            axi_wready <= 1'b0;
            axi_bvalid <= 1'b1;
            state_r    <= B_RESP;
          end
        end
        B_RESP: begin
          if (axi_bready) begin
            axi_bvalid <= 1'b0;
            state_r    <= IDLE;
          end
        end
        AR_ACK: begin
          axi_arready <= 1'b0;
          state_r     <= R_FETCH;
        end
        R_FETCH: begin
          axi_rdata  <= rd_data_r;
          axi_rvalid <= 1'b1;
          state_r    <= R_DATA;
        end
        R_DATA: begin
          // rdata is deliberately left as-is after the handshake
          if (axi_rready) begin
            axi_rvalid <= 1'b0;
            state_r    <= IDLE;
          end
        end
        default: begin
          axi_awready <= 1'b0;
          axi_wready  <= 1'b0;
          axi_bvalid  <= 1'b0;
          axi_arready <= 1'b0;
          axi_rvalid  <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  // SRAM array: byte-strobed write on the W handshake edge, read issued as AR_ACK closes.
  always_ff @(posedge CLK) begin
    if (wr_en_s) begin
      for (int b = 0; b < BITS/8; b++) begin
        if (axi_wstrb[b]) begin
          mem_r[addr_r][8*b +: 8] <= axi_wdata[8*b +: 8];
        end
      end
    end
    if (rd_en_s) begin
      rd_data_r <= mem_r[addr_r];
    end
  end

endmodule

// File: tb/tb_axi_sp32b1024_interconnect.sv
// Directed bench for axi_sp32b1024_interconnect: handshake timing, data, strobes,
// address aliasing, write-over-read priority and reset abort.
module tb_axi_sp32b1024_interconnect;

  localparam int TMO = 16;

  logic        CLK = 1'b0;
  logic        RST;
  logic        axi_awvalid, axi_awready;
  logic [31:0] axi_awaddr;
  logic [2:0]  axi_awprot;
  logic        axi_wvalid, axi_wready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_bvalid, axi_bready;
  logic        axi_arvalid, axi_arready;
  logic [31:0] axi_araddr;
  logic [2:0]  axi_arprot;
  logic        axi_rvalid, axi_rready;
  logic [31:0] axi_rdata;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [63:0] xs_r;

  axi_sp32b1024_interconnect dut (
    .CLK(CLK), .RST(RST),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
    .axi_awprot(axi_awprot),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
    .axi_wstrb(axi_wstrb),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
    .axi_arprot(axi_arprot),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vec_cnt);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] xs_next(input logic [63:0] x);
    logic [63:0] y;
    y = x;
    y = y ^ (y << 13);
    y = y ^ (y >> 7);
    y = y ^ (y << 17);
    return y;
  endfunction

  // Master holds awvalid/wvalid until the B handshake; entered and left on a negedge.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int bdelay);
    int n;
    axi_awaddr = addr; axi_awvalid = 1'b1;
    axi_wdata = data; axi_wstrb = strb; axi_wvalid = 1'b1; axi_bready = 1'b0;
    n = 0;
    do begin @(negedge CLK); n++; end while (!axi_awready && n < TMO);
    check("awready_lat", n, 1);
    @(negedge CLK);
    check("awready_pulse", {31'd0, axi_awready}, 32'd0);
    check("wready_lat", {31'd0, axi_wready}, 32'd1);
    @(negedge CLK);
    check("wready_drop", {31'd0, axi_wready}, 32'd0);
    check("bvalid_lat", {31'd0, axi_bvalid}, 32'd1);
    for (int i = 0; i < bdelay; i++) begin
      @(negedge CLK);
      check("bvalid_hold", {31'd0, axi_bvalid}, 32'd1);
    end
    axi_bready = 1'b1;
    @(negedge CLK);
    check("bvalid_done", {31'd0, axi_bvalid}, 32'd0);
    check("no_reissue", {31'd0, axi_awready}, 32'd0);
    axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp, input int rdelay);
    int n;
    axi_araddr = addr; axi_arvalid = 1'b1; axi_rready = 1'b0;
    n = 0;
    do begin @(negedge CLK); n++; end while (!axi_arready && n < TMO);
    check("arready_lat", n, 1);
    axi_arvalid = 1'b0;
    @(negedge CLK);
    check("arready_pulse", {31'd0, axi_arready}, 32'd0);
    check("rvalid_early", {31'd0, axi_rvalid}, 32'd0);
    @(negedge CLK);
    check("rvalid_lat", {31'd0, axi_rvalid}, 32'd1);
    check("rdata", axi_rdata, exp);
    for (int i = 0; i < rdelay; i++) begin
      @(negedge CLK);
      check("rvalid_hold", {31'd0, axi_rvalid}, 32'd1);
      check("rdata_hold", axi_rdata, exp);
    end
    axi_rready = 1'b1;
    @(negedge CLK);
    check("rvalid_done", {31'd0, axi_rvalid}, 32'd0);
    check("rdata_keep", axi_rdata, exp);
    axi_rready = 1'b0;
  endtask

  initial begin
    RST = 1'b0;
    axi_awvalid = 1'b0; axi_awaddr = 32'd0; axi_awprot = 3'd0;
    axi_wvalid = 1'b0; axi_wdata = 32'd0; axi_wstrb = 4'd0; axi_bready = 1'b0;
    axi_arvalid = 1'b0; axi_araddr = 32'd0; axi_arprot = 3'd0; axi_rready = 1'b0;

    repeat (5) @(negedge CLK);
    check("rst_awready", {31'd0, axi_awready}, 32'd0);
    check("rst_wready", {31'd0, axi_wready}, 32'd0);
    check("rst_bvalid", {31'd0, axi_bvalid}, 32'd0);
    check("rst_arready", {31'd0, axi_arready}, 32'd0);
    check("rst_rvalid", {31'd0, axi_rvalid}, 32'd0);
    check("rst_rdata", axi_rdata, 32'd0);
    RST = 1'b1;
    @(negedge CLK);

    // single write held through a delayed bready, then read back with delayed rready
    axi_write(32'h5, 32'hDEADBEEF, 4'hF, 2);
    @(negedge CLK);
    check("single_one_write", {31'd0, axi_awready}, 32'd0);
    axi_read(32'h5, 32'hDEADBEEF, 2);

    // full sweep: fill, then rewrite and read each word back
    xs_r = 64'd88172645463325252;
    for (int a = 0; a < 1024; a++) begin
      xs_r = xs_next(xs_r);
      axi_write(a, xs_r[31:0], 4'hF, 0);
    end
    for (int a = 0; a < 1024; a++) begin
      xs_r = xs_next(xs_r);
      axi_write(a, xs_r[31:0], 4'hF, 0);
      axi_read(a, xs_r[31:0], 0);
    end

    // byte strobes
    axi_write(32'h3, 32'hFFFFFFFF, 4'hF, 0);
    axi_write(32'h3, 32'h12345678, 4'b0010, 0);
    axi_read(32'h3, 32'hFFFF56FF, 0);
    axi_write(32'h3, 32'hAABBCCDD, 4'b1001, 0);
    axi_read(32'h3, 32'hAAFF56DD, 0);

    // aliasing: index = addr mod 1024, upper bits ignored
    axi_write(32'h400, 32'hCAFEF00D, 4'hF, 0);
    axi_read(32'h0, 32'hCAFEF00D, 0);
    axi_write(32'hFFFF_F7FF, 32'h0BADF00D, 4'hF, 0);
    axi_read(32'h3FF, 32'h0BADF00D, 1);

    // write and read requested together: write first, then the read sees new data
    axi_write(32'h7, 32'h01010101, 4'hF, 0);
    axi_araddr = 32'h7; axi_arvalid = 1'b1;
    axi_write(32'h7, 32'hA5A5C3C3, 4'hF, 0);
    check("arb_no_ar_during_wr", {31'd0, axi_arready}, 32'd0);
    axi_read(32'h7, 32'hA5A5C3C3, 0);

    // reset while waiting for W: write must not land, FSM back to IDLE
    axi_write(32'h9, 32'h11111111, 4'hF, 0);
    axi_awaddr = 32'h9; axi_awvalid = 1'b1; axi_wvalid = 1'b0;
    axi_wdata = 32'h22222222; axi_wstrb = 4'hF;
    @(negedge CLK);
    check("abort_awready", {31'd0, axi_awready}, 32'd1);
    @(negedge CLK);
    check("abort_wready", {31'd0, axi_wready}, 32'd1);
    axi_awvalid = 1'b0;
    RST = 1'b0;
    #1;
    check("abort_wready_drop", {31'd0, axi_wready}, 32'd0);
    axi_wvalid = 1'b1;
    repeat (2) @(negedge CLK);
    axi_wvalid = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    check("abort_bvalid", {31'd0, axi_bvalid}, 32'd0);
    check("abort_wready_idle", {31'd0, axi_wready}, 32'd0);
    axi_read(32'h9, 32'h11111111, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
